// File: rtl/mpadder_pkg.sv
// mpadder_pkg: shared defaults, chunk-count derivation and FSM state type for mp_serial_adder
package mpadder_pkg;
    localparam int WIDTH_DEF   = 1027;
    localparam int CHUNK_W_DEF = 128;

    // Number of CHUNK_W slices needed to cover a (w+1)-bit result.
    function automatic int nchunk(input int w, input int c);
        return (w + c) / c;
    endfunction

    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/mp_chunk_adder.sv
// mp_chunk_adder: combinational W-bit adder with carry in/out
//   a, b      : W-bit addends
//   carry_in  : incoming carry
//   sum       : W-bit sum
//   carry_out : carry out of the top bit
module mp_chunk_adder #(
    parameter int W = 128
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    output logic [W-1:0] sum,
    output logic         carry_out
);
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
endmodule

// File: rtl/mp_serial_adder.sv
// mp_serial_adder: multi-cycle multi-precision adder/subtractor with start/done handshake
//   clk      : rising-edge clock
//   resetn   : asynchronous active-low reset
//   start    : request, accepted while idle
//   subtract : 0 = a+b, 1 = a-b (sampled with start)
//   in_a     : WIDTH-bit unsigned operand a (sampled with start)
//   in_b     : WIDTH-bit unsigned operand b (sampled with start)
//   result   : WIDTH+1-bit sum or difference mod 2^(WIDTH+1)
//   done     : level, high from completion until the next accepted start
// Build option MPADDER_SINGLE_CYCLE_EN: full-width add in one BUSY cycle
// instead of CHUNK_W-bit slices over NCHUNK cycles.
module mp_serial_adder
    import mpadder_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CHUNK_W = CHUNK_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             done
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK_W);
    localparam int P      = NCHUNK * CHUNK_W;
`ifdef MPADDER_SINGLE_CYCLE_EN
    localparam int ADD_W  = P;
`else
    localparam int ADD_W  = CHUNK_W;
    localparam int IW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
`endif

    state_t           state;
    logic [P-1:0]     a_reg;
    logic [P-1:0]     b_reg;
    logic             carry;
    logic [ADD_W-1:0] s;
    logic             c_out;
    logic [P-1:0]     sum_full;
    logic             last;

    // The adder always works on the low ADD_W bits; in the serial build the
    // operand registers shift down one chunk per cycle to feed it.
    mp_chunk_adder #(.W(ADD_W)) u_add (
        .a        (a_reg[ADD_W-1:0]),
        .b        (b_reg[ADD_W-1:0]),
        .carry_in (carry),
        .sum      (s),
        .carry_out(c_out)
    );

`ifdef MPADDER_SINGLE_CYCLE_EN
    assign sum_full = s;
    assign last     = 1'b1;
`else
    logic [IW-1:0]         idx;
    // Completed chunks enter at the top and shift down, so after the last
    // chunk chunk 0 sits at bit 0 of sum_full.
    logic [P-CHUNK_W-1:0]  sum_reg;
    assign sum_full = {s, sum_reg};
    assign last     = idx == IW'(NCHUNK - 1);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            carry  <= 1'b0;
            result <= '0;
            done   <= 1'b0;
`ifndef MPADDER_SINGLE_CYCLE_EN
            idx     <= '0;
            sum_reg <= '0;
`endif
        end else if (state == IDLE) begin
            if (start) begin
                // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
                a_reg <= P'(in_a);
                b_reg <= subtract ? ~P'(in_b) : P'(in_b);
                carry <= subtract;
                done  <= 1'b0;
                state <= BUSY;
`ifndef MPADDER_SINGLE_CYCLE_EN
                idx   <= '0;
`endif
            end
        end else begin
            carry <= c_out;
`ifndef MPADDER_SINGLE_CYCLE_EN
            a_reg   <= a_reg >> CHUNK_W;
            b_reg   <= b_reg >> CHUNK_W;
            sum_reg <= sum_full[P-1:CHUNK_W];
            idx     <= idx + 1'b1;
`endif
            if (last) begin
                result <= sum_full[WIDTH:0];
                done   <= 1'b1;
                state  <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mp_serial_adder.sv
// tb_mp_serial_adder: directed self-checking bench for mp_serial_adder
module tb_mp_serial_adder;
    localparam int W = 1027;
`ifdef MPADDER_SINGLE_CYCLE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 9;
`endif
    localparam logic [W-1:0] A1 = {3'h5, {32{32'hc5e1a3f7}}};
    localparam logic [W-1:0] B1 = {3'h5, {32{32'h46409b2d}}};
    localparam logic [W:0]   E1 = {4'hb, {31{32'h0c223f25}}, 32'h0c223f24};
    localparam logic [W-1:0] A2 = {3'h4, {32{32'h43c10a5e}}};
    localparam logic [W-1:0] B2 = {3'h5, {32{32'hf4f00001}}};
    localparam logic [W:0]   E2 = {4'he, {31{32'h4ed10a5c}}, 32'h4ed10a5d};

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W:0]   result;
    logic         done;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    mp_serial_adder dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .subtract(subtract),
        .in_a    (in_a),
        .in_b    (in_b),
        .result  (result),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h..%h expected %h..%h", tag, got[W:W-63], got[63:0], exp[W:W-63], exp[63:0]);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W:0] exp);
        int n;
        @(negedge clk);
        in_a = a;
        in_b = b;
        subtract = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_a = ~a;
        in_b = ~b;
        subtract = ~s;
        chk({tag, "_clr"}, (W+1)'(done), '0);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, (W+1)'(n), (W+1)'(LAT));
        chk(tag, result, exp);
    endtask

    initial begin
        int rises;
        logic prev;
        #1 resetn = 1'b0;
        #20;
        chk("rst_result", result, '0);
        chk("rst_done", (W+1)'(done), '0);
        @(negedge clk) resetn = 1'b1;

        run_op("add_2_5", 2, 5, 1'b0, 7);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_done", (W+1)'(done), 1);
        chk("hold_res", result, 7);
        run_op("add_big", A1, B1, 1'b0, E1);
        run_op("add_chain", '1, 1, 1'b0, {1'b1, {W{1'b0}}});
        run_op("sub_big", A2, B2, 1'b1, E2);
        run_op("sub_4_8", 4, 8, 1'b1, {{(W-1){1'b1}}, 2'b00});
        run_op("sub_8_4", 8, 4, 1'b1, 4);
        run_op("sub_x_x", A1, A1, 1'b1, '0);

        // start held high into the first BUSY edge with new operands
        @(negedge clk);
        in_a = 2;
        in_b = 5;
        subtract = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        in_a = 100;
        in_b = 200;
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
            if (done && !prev) rises++;
            prev = done;
        end
        chk("busy_rises", (W+1)'(rises), 1);
        chk("busy_res", result, 7);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        in_a = A1;
        in_b = B1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("abort_done", (W+1)'(done), '0);
        chk("abort_res", result, '0);
        @(negedge clk) resetn = 1'b1;
        rises = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) rises++;
        end
        chk("abort_no_done", (W+1)'(rises), '0);
        run_op("post_reset", A2, B2, 1'b1, E2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
